// File: rtl/instr_sequencer.sv
// Host-side instruction sequencer for the cpu start/load/wait handshake.
// Holds a small program RAM and issues one instruction at a time. After each
// issue it waits for cpu_w to fall and then rise again, captures the cpu
// result and flags, and moves on until the programmed length is exhausted.
// A per-phase cycle counter guards against a cpu that never responds.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | after reset; accepts program writes and start
//   ISSUE   | waiting for cpu_w=1, then strobes cpu_load/cpu_s for one cycle
//   WAITLO  | waiting for the cpu to drop cpu_w (execution began)
//   WAITHI  | waiting for the cpu to raise cpu_w (execution finished)
//   CAPTURE | latch cpu_out and flags, advance pc or finish
//   DONE    | run complete; done held high until the next start
//   ERR     | handshake timed out; timeout_err held high until the next start
module instr_sequencer #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  input  logic          cpu_w,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic [15:0]   result,
  output logic [2:0]    result_flags,
  output logic          result_valid,
  output logic          done,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAITLO, WAITHI, CAPTURE, DONE, ERR
  } state_t;

  state_t          state_q;
  logic [AW:0]     len_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   pc_q;
  logic [15:0]     cpu_in_q;
  logic            cpu_load_q;
  logic            cpu_s_q;
  logic            busy_q;
  logic [15:0]     result_q;
  logic [2:0]      flags_q;
  logic            valid_q;
  logic            done_q;
  logic            err_q;

  logic [15:0]     mem_q [2**AW];

  logic            ready;
  logic [CW-1:0]   cnt_d;
  logic            to_hit;
  logic            last;

  assign ready  = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign cnt_d  = cnt_q + CW'(1);
  assign to_hit = (cnt_d == TO_MAX);
  assign last   = ({1'b0, pc_q} == (len_q - {{AW{1'b0}}, 1'b1}));

  // Program RAM: writes accepted only while no run is in progress.
  always_ff @(posedge clk) begin
    if (prog_we && ready) mem_q[prog_addr] <= prog_data;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      cpu_in_q   <= '0;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      valid_q    <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            len_q  <= prog_len;
            pc_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (prog_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              busy_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cpu_w) begin
            cpu_in_q   <= mem_q[pc_q];
            cpu_load_q <= 1'b1;
            cpu_s_q    <= 1'b1;
            cnt_q      <= '0;
            state_q    <= WAITLO;
          end else if (to_hit) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAITLO: begin
          if (!cpu_w) begin
            cnt_q   <= '0;
            state_q <= WAITHI;
          end else if (to_hit) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAITHI: begin
          if (cpu_w) begin
            state_q <= CAPTURE;
          end else if (to_hit) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        CAPTURE: begin
          result_q <= cpu_out;
          flags_q  <= {cpu_N, cpu_V, cpu_Z};
          valid_q  <= 1'b1;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            pc_q    <= pc_q + AW'(1);
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_in       = cpu_in_q;
  assign cpu_load     = cpu_load_q;
  assign cpu_s        = cpu_s_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_flags = flags_q;
  assign result_valid = valid_q;
  assign done         = done_q;
  assign timeout_err  = err_q;

endmodule
